// File: rtl/codon_job_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// codon_job_sequencer
//
// Top-level job controller for the codon-search datapath. It holds the codon
// reader and codon counter in reset until a job starts. It then releases them
// and waits, under a watchdog, for both to finish. Finally it sweeps
// count_index over every codon and streams each (index, count) pair to a
// downstream consumer over a valid/ready handshake.
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous, active-high reset
//   start           job request, honoured only in IDLE, DONE or ERROR
//   done_reader     level from codon reader: codons loaded
//   done_counter    level from codon counter: genome scan complete
//   codon_count     count selected by count_index (combinational from counter)
//   out_ready       consumer ready
//   datapath_reset  synchronous reset to reader and counter
//   count_index     codon count select to counter
//   out_valid       out_index/out_count valid
//   out_index       codon number of the presented count
//   out_count       presented count
//   busy            job in progress
//   done            job complete, all counts delivered
//   error           watchdog expired
// -----------------------------------------------------------------------------
module codon_job_sequencer #(
    parameter int NUM_CODONS     = 5,
    parameter int CLEAR_CYCLES   = 2,
    parameter int TIMER_WIDTH    = 12,
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       done_reader,
    input  logic       done_counter,
    input  logic [3:0] codon_count,
    input  logic       out_ready,
    output logic       datapath_reset,
    output logic [2:0] count_index,
    output logic       out_valid,
    output logic [2:0] out_index,
    output logic [3:0] out_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CLEAR_WIDTH = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLEAR_WIDTH-1:0] CLEAR_LAST = CLEAR_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]             INDEX_LAST = 3'(NUM_CODONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_READER,
        S_WAIT_COUNTER,
        S_FETCH,
        S_PRESENT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  r_state;
    logic [CLEAR_WIDTH-1:0]  r_clearCnt;
    logic [TIMER_WIDTH-1:0]  r_timer;
    logic                    r_datapathReset;
    logic [2:0]              r_countIndex;
    logic                    r_outValid;
    logic [2:0]              r_outIndex;
    logic [3:0]              r_outCount;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    // Whole controller lives in one registered process so every output is a
    // flop and changes only on the clock edge that changes the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_clearCnt      <= '0;
            r_timer         <= '0;
            r_datapathReset <= 1'b1;
            r_countIndex    <= '0;
            r_outValid      <= 1'b0;
            r_outIndex      <= '0;
            r_outCount      <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_datapathReset <= 1'b1;
                    if (start) begin
                        r_state      <= S_CLEAR;
                        r_busy       <= 1'b1;
                        r_clearCnt   <= '0;
                        r_countIndex <= '0;
                    end
                end

                // Keep the datapath in reset long enough to wipe the previous
                // job's counts, then release it and arm the watchdog.
                S_CLEAR: begin
                    if (r_clearCnt == CLEAR_LAST) begin
                        r_state         <= S_WAIT_READER;
                        r_datapathReset <= 1'b0;
                        r_timer         <= '0;
                    end else begin
                        r_clearCnt <= r_clearCnt + 1'b1;
                    end
                end

                // A finished counter implies a finished reader, so done_counter
                // alone skips straight to the sweep. Any exit beats the
                // watchdog when both land on the same cycle.
                S_WAIT_READER: begin
                    if (done_counter) begin
                        r_state      <= S_FETCH;
                        r_countIndex <= '0;
                    end else if (done_reader) begin
                        r_state <= S_WAIT_COUNTER;
                        r_timer <= r_timer + 1'b1;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state         <= S_ERROR;
                        r_busy          <= 1'b0;
                        r_error         <= 1'b1;
                        r_datapathReset <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // The timer is deliberately not cleared here: one watchdog
                // budget covers both wait phases together.
                S_WAIT_COUNTER: begin
                    if (done_counter) begin
                        r_state      <= S_FETCH;
                        r_countIndex <= '0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state         <= S_ERROR;
                        r_busy          <= 1'b0;
                        r_error         <= 1'b1;
                        r_datapathReset <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // count_index was set on the previous edge. This cycle lets the
                // counter's combinational mux settle before capture.
                S_FETCH: begin
                    r_outCount <= codon_count;
                    r_outIndex <= r_countIndex;
                    r_outValid <= 1'b1;
                    r_state    <= S_PRESENT;
                end

                // Hold the pair until the consumer takes it. The last index
                // ends the job instead of wrapping.
                S_PRESENT: begin
                    if (r_outValid && out_ready) begin
                        r_outValid <= 1'b0;
                        if (r_countIndex == INDEX_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_countIndex <= r_countIndex + 3'd1;
                            r_state      <= S_FETCH;
                        end
                    end
                end

                // The datapath stays out of reset so the counts remain readable.
                S_DONE: begin
                    r_datapathReset <= 1'b0;
                    if (start) begin
                        r_state         <= S_CLEAR;
                        r_done          <= 1'b0;
                        r_busy          <= 1'b1;
                        r_clearCnt      <= '0;
                        r_countIndex    <= '0;
                        r_datapathReset <= 1'b1;
                    end
                end

                S_ERROR: begin
                    r_datapathReset <= 1'b1;
                    if (start) begin
                        r_state      <= S_CLEAR;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_clearCnt   <= '0;
                        r_countIndex <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign datapath_reset = r_datapathReset;
    assign count_index    = r_countIndex;
    assign out_valid      = r_outValid;
    assign out_index      = r_outIndex;
    assign out_count      = r_outCount;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;

endmodule

// File: tb/tb_codon_job_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_codon_job_sequencer
//
// Directed bench for codon_job_sequencer. It models the codon counter's
// count mux with a fixed table. It then walks through normal jobs,
// consumer back-pressure, watchdog expiry in both wait states, a
// timeout/exit collision, reset during a transfer, and ignored or held start
// requests.
// -----------------------------------------------------------------------------
module tb_codon_job_sequencer;

    localparam int NUM_CODONS = 5;
    localparam int TIMEOUT    = 4000;

    logic       clock;
    logic       reset;
    logic       start;
    logic       done_reader;
    logic       done_counter;
    logic [3:0] codon_count;
    logic       out_ready;
    logic       datapath_reset;
    logic [2:0] count_index;
    logic       out_valid;
    logic [2:0] out_index;
    logic [3:0] out_count;
    logic       busy;
    logic       done;
    logic       error;

    int total = 0;
    int bad   = 0;

    logic [3:0] countModel [0:7];

    // Stand-in for the codon counter: count_index selects a stored count.
    assign codon_count = countModel[count_index];

    codon_job_sequencer #(
        .NUM_CODONS    (NUM_CODONS),
        .CLEAR_CYCLES  (2),
        .TIMER_WIDTH   (12),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .done_reader   (done_reader),
        .done_counter  (done_counter),
        .codon_count   (codon_count),
        .out_ready     (out_ready),
        .datapath_reset(datapath_reset),
        .count_index   (count_index),
        .out_valid     (out_valid),
        .out_index     (out_index),
        .out_count     (out_count),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a wait never resolves.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog bench did not complete total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] bench timed out");
    end

    // Step one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic dr, input logic dc, input logic rdy);
        start        = s;
        done_reader  = dr;
        done_counter = dc;
        out_ready    = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start pulse from an idle state, then the two clear cycles and release.
    task automatic startJob();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("startBusy", busy, 1);
        checkOutput("startDpr", datapath_reset, 1);
        checkOutput("startDone", done, 0);
        checkOutput("startErr", error, 0);
        checkOutput("startIdx", count_index, 0);
        tick();
        checkOutput("clearDpr", datapath_reset, 1);
        tick();
        checkOutput("releaseDpr", datapath_reset, 0);
        checkOutput("releaseBusy", busy, 1);
    endtask

    // Entered with the first pair already presented. mode 0: always ready,
    // and transfers must be 2 cycles apart. mode 1: ready one cycle in three.
    // Every cycle with out_valid high must show the next expected pair.
    task automatic sweep(input int mode);
        int n;
        int cyc;
        int lastXfer;
        n        = 0;
        cyc      = 0;
        lastXfer = -1;
        while (n < NUM_CODONS && cyc < 100) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
            checkOutput("idxMax", (count_index <= 3'd4), 1);
            if (out_valid) begin
                checkOutput("pairIdx", out_index, n);
                checkOutput("pairCnt", out_count, countModel[n]);
                checkOutput("doneEarly", done, 0);
                if (out_ready) begin
                    if (mode == 0 && lastXfer >= 0) checkOutput("spacing", cyc - lastXfer, 2);
                    lastXfer = cyc;
                    n++;
                end
            end
            tick();
            cyc++;
        end
        checkOutput("xferCount", n, NUM_CODONS);
        checkOutput("endDone", done, 1);
        checkOutput("endBusy", busy, 0);
        checkOutput("endValid", out_valid, 0);
        checkOutput("endErr", error, 0);
        checkOutput("endDpr", datapath_reset, 0);
        checkOutput("endIdx", count_index, NUM_CODONS - 1);
    endtask

    initial begin
        logic sawValid;
        logic found;
        int   extra;

        countModel = '{4'd3, 4'd0, 4'd7, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0};
        reset = 1'b1;
        applyStimulus(0, 0, 0, 1);
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rstDpr", datapath_reset, 1);
        checkOutput("rstIdx", count_index, 0);
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstOutIdx", out_index, 0);
        checkOutput("rstOutCnt", out_count, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstErr", error, 0);

        $display("[TB] normal job, consumer always ready");
        startJob();
        repeat (8) tick();
        checkOutput("waitRdBusy", busy, 1);
        applyStimulus(0, 1, 0, 1);
        repeat (40) tick();
        checkOutput("waitCntValid", out_valid, 0);
        checkOutput("waitCntErr", error, 0);
        applyStimulus(0, 1, 1, 1);
        tick();
        checkOutput("fetchValid", out_valid, 0);
        checkOutput("fetchIdx", count_index, 0);
        tick();
        checkOutput("latValid", out_valid, 1);
        sweep(0);

        $display("[TB] restart from DONE, reader and counter together, stalled consumer");
        applyStimulus(0, 0, 0, 0);
        startJob();
        repeat (5) tick();
        applyStimulus(0, 1, 1, 0);
        tick();
        checkOutput("bothFetchValid", out_valid, 0);
        checkOutput("bothFetchErr", error, 0);
        tick();
        checkOutput("bothValid", out_valid, 1);
        sweep(1);

        $display("[TB] reader never finishes");
        applyStimulus(0, 0, 0, 0);
        startJob();
        sawValid = 1'b0;
        repeat (TIMEOUT - 1) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("toEarlyErr", error, 0);
        checkOutput("toEarlyBusy", busy, 1);
        tick();
        checkOutput("toErr", error, 1);
        checkOutput("toDpr", datapath_reset, 1);
        checkOutput("toBusy", busy, 0);
        checkOutput("toDone", done, 0);
        checkOutput("toNoValid", sawValid, 0);

        $display("[TB] restart from ERROR, counter finishes alone");
        startJob();
        repeat (5) tick();
        applyStimulus(0, 0, 1, 1);
        tick();
        tick();
        checkOutput("aloneValid", out_valid, 1);
        sweep(0);

        $display("[TB] reader finishes, counter never does");
        applyStimulus(0, 0, 0, 0);
        startJob();
        repeat (99) tick();
        applyStimulus(0, 1, 0, 0);
        repeat (TIMEOUT - 100) tick();
        checkOutput("to2EarlyErr", error, 0);
        tick();
        checkOutput("to2Err", error, 1);
        checkOutput("to2Busy", busy, 0);

        $display("[TB] counter finishes on the last watchdog cycle");
        applyStimulus(0, 0, 0, 0);
        startJob();
        repeat (99) tick();
        applyStimulus(0, 1, 0, 1);
        repeat (TIMEOUT - 100) tick();
        applyStimulus(0, 1, 1, 1);
        tick();
        checkOutput("edgeErr", error, 0);
        checkOutput("edgeBusy", busy, 1);
        checkOutput("edgeValid", out_valid, 0);
        tick();
        checkOutput("edgeValid2", out_valid, 1);
        sweep(0);

        $display("[TB] reset while presenting index 2");
        applyStimulus(0, 0, 0, 0);
        startJob();
        applyStimulus(0, 1, 1, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (out_valid && out_index == 3'd2) found = 1'b1;
        end
        checkOutput("reachIdx2", found, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("midRstDpr", datapath_reset, 1);
        checkOutput("midRstIdx", count_index, 0);
        checkOutput("midRstValid", out_valid, 0);
        checkOutput("midRstOutIdx", out_index, 0);
        checkOutput("midRstOutCnt", out_count, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstErr", error, 0);
        startJob();
        applyStimulus(0, 0, 1, 1);
        tick();
        tick();
        checkOutput("againValid", out_valid, 1);
        checkOutput("againIdx", out_index, 0);
        sweep(0);

        $display("[TB] start ignored while busy");
        applyStimulus(0, 0, 0, 0);
        startJob();
        applyStimulus(0, 1, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        tick();
        applyStimulus(0, 1, 0, 0);
        checkOutput("wcStartDpr", datapath_reset, 0);
        checkOutput("wcStartBusy", busy, 1);
        tick();
        tick();
        checkOutput("wcStartDpr2", datapath_reset, 0);
        applyStimulus(0, 1, 1, 0);
        tick();
        tick();
        checkOutput("presValid", out_valid, 1);
        applyStimulus(1, 1, 1, 0);
        tick();
        applyStimulus(0, 1, 1, 0);
        checkOutput("presStartValid", out_valid, 1);
        checkOutput("presStartIdx", out_index, 0);
        checkOutput("presStartDpr", datapath_reset, 0);
        sweep(0);

        $display("[TB] start held high through DONE");
        applyStimulus(1, 0, 0, 1);
        tick();
        checkOutput("holdBusy", busy, 1);
        checkOutput("holdDone", done, 0);
        checkOutput("holdDpr", datapath_reset, 1);
        tick();
        tick();
        checkOutput("holdRelease", datapath_reset, 0);
        extra = 0;
        repeat (10) begin
            tick();
            if (datapath_reset || !busy) extra++;
        end
        checkOutput("holdOneRestart", extra, 0);
        applyStimulus(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
